// File: rtl/zoom_pkg.sv
// Shared constants for the zoom coordinate pipeline: mode encodings,
// scale shifts, screen geometry and the per-mode display size/origin table.
package zoom_pkg;

  typedef enum logic [2:0] {
    MODE_1X   = 3'b000,
    MODE_IN2  = 3'b001,
    MODE_IN4  = 3'b010,
    MODE_OUT2 = 3'b011,
    MODE_OUT4 = 3'b100
  } zoom_mode_e;

  typedef enum logic {
    ST_ACTIVE  = 1'b0,
    ST_PENDING = 1'b1
  } ctrl_state_e;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int SHIFT_1X = 0;
  localparam int SHIFT_2X = 1;
  localparam int SHIFT_4X = 2;

  // Codes above MODE_OUT4 are rejected by the mode controller.
  function automatic logic mode_legal(input logic [2:0] m);
    return (m <= MODE_OUT4);
  endfunction

  function automatic logic [1:0] mode_shift(input logic [2:0] m);
    case (m)
      MODE_IN2, MODE_OUT2: return 2'(SHIFT_2X);
      MODE_IN4, MODE_OUT4: return 2'(SHIFT_4X);
      default:             return 2'(SHIFT_1X);
    endcase
  endfunction

  function automatic logic mode_is_in(input logic [2:0] m);
    return (m == MODE_IN2) || (m == MODE_IN4);
  endfunction

  // Displayed extent along one axis for a source dimension dim.
  function automatic int disp_size(input logic [2:0] m, input int dim);
    if (mode_is_in(m)) return dim << mode_shift(m);
    return dim >> mode_shift(m);
  endfunction

  // Top/left corner that centres the displayed image on the screen axis.
  function automatic int mode_origin(input logic [2:0] m, input int dim, input int screen);
    return (screen - disp_size(m, dim)) / 2;
  endfunction

endpackage

// File: rtl/zoom_coord_pipe_if.sv
// Pixel-stream, mode-control and result signals of the zoom coordinate pipe.
interface zoom_coord_pipe_if #(
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 17
);
  logic               in_valid;
  logic [COORD_W-1:0] next_x;
  logic [COORD_W-1:0] next_y;
  logic [2:0]         ch;
  logic               ch_load;
  logic [COORD_W-1:0] pan_x;
  logic [COORD_W-1:0] pan_y;
  logic               frame_start;
  logic               out_valid;
  logic [COORD_W-1:0] img_x;
  logic [COORD_W-1:0] img_y;
  logic [ADDR_W-1:0]  address;
  logic               in_window;
  logic               zoom_done;
  logic               mode_err;
  logic [2:0]         mode_active;

  modport master (
    output in_valid, next_x, next_y, ch, ch_load, pan_x, pan_y, frame_start,
    input  out_valid, img_x, img_y, address, in_window, zoom_done, mode_err, mode_active
  );

  modport slave (
    input  in_valid, next_x, next_y, ch, ch_load, pan_x, pan_y, frame_start,
    output out_valid, img_x, img_y, address, in_window, zoom_done, mode_err, mode_active
  );
endinterface

// File: rtl/zoom_mode_ctrl.sv
// Mode controller: holds the active zoom mode, defers legal mode requests
// to the next frame boundary, rejects illegal codes and latches pan per frame.
module zoom_mode_ctrl
  import zoom_pkg::*;
#(
  parameter int IMG_W   = 160,
  parameter int IMG_H   = 120,
  parameter int COORD_W = 10
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic [2:0]         ch,
  input  logic               ch_load,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] pan_x,
  input  logic [COORD_W-1:0] pan_y,
  output logic [2:0]         mode_active,
  output logic [COORD_W-1:0] pan_x_lat,
  output logic [COORD_W-1:0] pan_y_lat,
  output logic               zoom_done,
  output logic               mode_err
);

  localparam logic [COORD_W-1:0] PAN_X_MAX = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] PAN_Y_MAX = COORD_W'(IMG_H - 1);

  ctrl_state_e        state_reg, state_next;
  logic [2:0]         mode_reg, mode_next;
  logic [2:0]         pending_reg, pending_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;
  logic [COORD_W-1:0] pan_x_reg, pan_x_next;
  logic [COORD_W-1:0] pan_y_reg, pan_y_next;
  logic               load_ok;

  // State, mode, pan and pulse registers.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_ACTIVE;
      mode_reg    <= MODE_1X;
      pending_reg <= MODE_1X;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      pan_x_reg   <= '0;
      pan_y_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      mode_reg    <= mode_next;
      pending_reg <= pending_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      pan_x_reg   <= pan_x_next;
      pan_y_reg   <= pan_y_next;
    end
  end

  // Next-state: a legal request arriving with frame_start applies at once,
  // otherwise it waits (overwriting any earlier pending request).
  always_comb begin
    state_next   = state_reg;
    mode_next    = mode_reg;
    pending_next = pending_reg;
    done_next    = 1'b0;
    err_next     = ch_load && !mode_legal(ch);
    load_ok      = ch_load && mode_legal(ch);
    pan_x_next   = pan_x_reg;
    pan_y_next   = pan_y_reg;

    case (state_reg)
      ST_ACTIVE: begin
        if (load_ok && frame_start) begin
          mode_next = ch;
          done_next = 1'b1;
        end else if (load_ok) begin
          pending_next = ch;
          state_next   = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (load_ok && frame_start) begin
          mode_next  = ch;
          done_next  = 1'b1;
          state_next = ST_ACTIVE;
        end else if (load_ok) begin
          pending_next = ch;
        end else if (frame_start) begin
          mode_next  = pending_reg;
          done_next  = 1'b1;
          state_next = ST_ACTIVE;
        end
      end
      default: state_next = ST_ACTIVE;
    endcase

    if (frame_start) begin
      pan_x_next = (pan_x > PAN_X_MAX) ? PAN_X_MAX : pan_x;
      pan_y_next = (pan_y > PAN_Y_MAX) ? PAN_Y_MAX : pan_y;
    end
  end

  assign mode_active = mode_reg;
  assign pan_x_lat   = pan_x_reg;
  assign pan_y_lat   = pan_y_reg;
  assign zoom_done   = done_reg;
  assign mode_err    = err_reg;

endmodule

// File: rtl/zoom_coord_pipe.sv
// Zoom coordinate pipeline: maps VGA scan coordinates to source-image
// coordinates and a frame-buffer address in three fixed stages
// (origin subtract, scale/window/pan, address multiply-add).
module zoom_coord_pipe
  import zoom_pkg::*;
#(
  parameter int IMG_W   = 160,
  parameter int IMG_H   = 120,
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 17
) (
  input  logic            clk_in,
  input  logic            reset,
  zoom_coord_pipe_if.slave bus
);

  // Signed relative coordinates need one bit beyond COORD_W.
  localparam int RW = COORD_W + 1;
  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);

  logic [2:0]         mode_active;
  logic [COORD_W-1:0] pan_x_lat, pan_y_lat;
  logic               zoom_done, mode_err;

  zoom_mode_ctrl #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .COORD_W (COORD_W)
  ) u_mode_ctrl (
    .clk_in      (clk_in),
    .reset       (reset),
    .ch          (bus.ch),
    .ch_load     (bus.ch_load),
    .frame_start (bus.frame_start),
    .pan_x       (bus.pan_x),
    .pan_y       (bus.pan_y),
    .mode_active (mode_active),
    .pan_x_lat   (pan_x_lat),
    .pan_y_lat   (pan_y_lat),
    .zoom_done   (zoom_done),
    .mode_err    (mode_err)
  );

  // Axis 0 is X, axis 1 is Y.
  logic [COORD_W-1:0]   next_c [2];
  logic [COORD_W-1:0]   pan_c  [2];
  logic signed [RW-1:0] org_tab  [2][8];
  logic signed [RW-1:0] disp_tab [2][8];
  logic [COORD_W-1:0]   s2_img [2];
  logic [1:0]           inside_c;
  logic                 in_win_c;

  assign next_c[0] = bus.next_x;
  assign next_c[1] = bus.next_y;
  assign pan_c[0]  = pan_x_lat;
  assign pan_c[1]  = pan_y_lat;
  assign in_win_c  = &inside_c;

  // Shared per-pixel sideband: valid flags and the mode captured on entry.
  logic       s1_valid_reg, s2_valid_reg, s2_win_reg;
  logic [2:0] s1_mode_reg;
  logic [1:0] s1_shift;
  logic       s1_zoom_in;

  assign s1_shift   = mode_shift(s1_mode_reg);
  assign s1_zoom_in = mode_is_in(s1_mode_reg);

  // Sideband registers for stages 1 and 2.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      s1_valid_reg <= 1'b0;
      s1_mode_reg  <= MODE_1X;
      s2_valid_reg <= 1'b0;
      s2_win_reg   <= 1'b0;
    end else begin
      s1_valid_reg <= bus.in_valid;
      s1_mode_reg  <= mode_active;
      s2_valid_reg <= s1_valid_reg;
      s2_win_reg   <= in_win_c;
    end
  end

  genvar gi, gm;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      localparam int DIM = (gi == 0) ? IMG_W  : IMG_H;
      localparam int SCR = (gi == 0) ? SCREEN_W : SCREEN_H;

      // Constant display-origin/size table, one entry per mode code.
      for (gm = 0; gm < 8; gm++) begin : g_mode
        assign org_tab[gi][gm]  = RW'(mode_origin(3'(gm), DIM, SCR));
        assign disp_tab[gi][gm] = RW'(disp_size(3'(gm), DIM));
      end

      logic signed [RW-1:0] rel_reg;
      logic [COORD_W-1:0]   pan_reg;
      logic [COORD_W-1:0]   img_reg;
      logic [RW-1:0]        src_c;
      logic [RW-1:0]        sum_c;
      logic [COORD_W-1:0]   wrap_c;

      // Stage 1: position relative to the displayed image, pan captured with it.
      always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
          rel_reg <= '0;
          pan_reg <= '0;
        end else begin
          rel_reg <= $signed({1'b0, next_c[gi]}) - org_tab[gi][mode_active];
          pan_reg <= pan_c[gi];
        end
      end

      // Negative rel is outside; compare signed so it never wraps to a large value.
      assign inside_c[gi] = !rel_reg[RW-1] && (rel_reg < disp_tab[gi][s1_mode_reg]);
      assign src_c  = s1_zoom_in ? ($unsigned(rel_reg) >> s1_shift)
                                 : ($unsigned(rel_reg) << s1_shift);
      assign sum_c  = src_c + RW'(pan_reg);
      assign wrap_c = COORD_W'((sum_c >= RW'(DIM)) ? (sum_c - RW'(DIM)) : sum_c);

      // Stage 2: scaled, panned source coordinate; zero outside the window.
      always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
          img_reg <= '0;
        end else begin
          img_reg <= in_win_c ? wrap_c : '0;
        end
      end

      assign s2_img[gi] = img_reg;
    end
  endgenerate

  logic               out_valid_reg, in_window_reg;
  logic [COORD_W-1:0] img_x_reg, img_y_reg;
  logic [ADDR_W-1:0]  address_reg, address_next;

  assign address_next = ADDR_W'(s2_img[1]) * IMG_W_A + ADDR_W'(s2_img[0]);

  // Stage 3: linear frame-buffer address and output registers.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      out_valid_reg <= 1'b0;
      in_window_reg <= 1'b0;
      img_x_reg     <= '0;
      img_y_reg     <= '0;
      address_reg   <= '0;
    end else begin
      out_valid_reg <= s2_valid_reg;
      in_window_reg <= s2_win_reg;
      img_x_reg     <= s2_img[0];
      img_y_reg     <= s2_img[1];
      address_reg   <= address_next;
    end
  end

  assign bus.out_valid   = out_valid_reg;
  assign bus.in_window   = in_window_reg;
  assign bus.img_x       = img_x_reg;
  assign bus.img_y       = img_y_reg;
  assign bus.address     = address_reg;
  assign bus.zoom_done   = zoom_done;
  assign bus.mode_err    = mode_err;
  assign bus.mode_active = mode_active;

endmodule

// File: tb/tb_zoom_coord_pipe.sv
// Directed self-checking bench for zoom_coord_pipe.
module tb_zoom_coord_pipe;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  zoom_coord_pipe_if #(.COORD_W(10), .ADDR_W(17)) bus ();

  zoom_coord_pipe #(
    .IMG_W(160), .IMG_H(120), .COORD_W(10), .ADDR_W(17)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One isolated pixel; result expected exactly three cycles later.
  task automatic pixel(input int x, input int y, input int ex, input int ey,
                       input int ea, input int ew, input string tag);
    @(negedge clk_in);
    bus.in_valid = 1'b1;
    bus.next_x   = 10'(x);
    bus.next_y   = 10'(y);
    @(negedge clk_in);
    bus.in_valid = 1'b0;
    @(negedge clk_in);
    check({tag, ".early"}, 32'(bus.out_valid), 0);
    @(negedge clk_in);
    check({tag, ".valid"}, 32'(bus.out_valid), 1);
    check({tag, ".img_x"}, 32'(bus.img_x), ex);
    check({tag, ".img_y"}, 32'(bus.img_y), ey);
    check({tag, ".addr"},  32'(bus.address), ea);
    check({tag, ".win"},   32'(bus.in_window), ew);
    $display("pixel %s (%0d,%0d) -> img (%0d,%0d) addr %0d win %0d",
             tag, x, y, bus.img_x, bus.img_y, bus.address, bus.in_window);
  endtask

  // Frame boundary pulse; checks the zoom_done pulse and resulting mode.
  task automatic frame(input int exp_done, input int exp_mode, input string tag);
    @(negedge clk_in);
    bus.frame_start = 1'b1;
    @(negedge clk_in);
    bus.frame_start = 1'b0;
    check({tag, ".done"}, 32'(bus.zoom_done), exp_done);
    check({tag, ".mode"}, 32'(bus.mode_active), exp_mode);
    @(negedge clk_in);
    check({tag, ".done_off"}, 32'(bus.zoom_done), 0);
    $display("frame %s mode_active %0d", tag, bus.mode_active);
  endtask

  // Mode request pulse; checks mode_err the following cycle.
  task automatic load(input int code, input int exp_err, input int exp_mode, input string tag);
    @(negedge clk_in);
    bus.ch_load = 1'b1;
    bus.ch      = 3'(code);
    @(negedge clk_in);
    bus.ch_load = 1'b0;
    check({tag, ".err"},  32'(bus.mode_err), exp_err);
    check({tag, ".mode"}, 32'(bus.mode_active), exp_mode);
    $display("load %s ch %0d mode_err %0d", tag, code, bus.mode_err);
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.next_x      = '0;
    bus.next_y      = '0;
    bus.ch          = '0;
    bus.ch_load     = 1'b0;
    bus.pan_x       = '0;
    bus.pan_y       = '0;
    bus.frame_start = 1'b0;

    // Reset state
    repeat (2) @(negedge clk_in);
    check("rst.valid", 32'(bus.out_valid), 0);
    check("rst.mode",  32'(bus.mode_active), 0);
    check("rst.done",  32'(bus.zoom_done), 0);
    check("rst.err",   32'(bus.mode_err), 0);
    check("rst.addr",  32'(bus.address), 0);
    reset = 1'b1;

    // 1x, centred window corners
    pixel(240, 180, 0, 0, 0, 1, "1x_origin");
    pixel(239, 180, 0, 0, 0, 0, "1x_left_out");
    pixel(399, 299, 159, 119, 19199, 1, "1x_corner");

    // Pan only takes effect at frame_start
    bus.pan_x = 10'd10;
    pixel(240, 180, 0, 0, 0, 1, "pan_unlatched");
    frame(0, 0, "pan10");
    pixel(399, 180, 9, 0, 9, 1, "pan_wrap");
    pixel(240, 180, 10, 0, 10, 1, "pan_plain");
    bus.pan_x = 10'd500;
    bus.pan_y = 10'd200;
    frame(0, 0, "pan_clamp");
    pixel(240, 180, 159, 119, 19199, 1, "pan_clamped");
    bus.pan_x = '0;
    bus.pan_y = '0;
    frame(0, 0, "pan0");

    // Back-to-back stream, one result per cycle
    for (int c = 0; c < 7; c++) begin
      @(negedge clk_in);
      if (c >= 3) begin
        check("stream.valid", 32'(bus.out_valid), 1);
        check("stream.img_x", 32'(bus.img_x), 32'(c - 3));
        check("stream.addr",  32'(bus.address), 32'((c - 3) * 161));
        $display("stream beat %0d addr %0d", c - 3, bus.address);
      end
      if (c < 4) begin
        bus.in_valid = 1'b1;
        bus.next_x   = 10'(240 + c);
        bus.next_y   = 10'(180 + c);
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    @(negedge clk_in);
    check("stream.end", 32'(bus.out_valid), 0);

    // Mid-frame request waits for frame_start
    load(1, 0, 0, "req_in2");
    pixel(240, 180, 0, 0, 0, 1, "pending_1x");
    frame(1, 1, "apply_in2");

    // In 2x
    pixel(479, 359, 159, 119, 19199, 1, "in2_corner");
    pixel(480, 359, 0, 0, 0, 0, "in2_right_out");
    pixel(160, 120, 0, 0, 0, 1, "in2_origin");

    // Request and frame_start together: applies at that boundary
    @(negedge clk_in);
    bus.ch_load     = 1'b1;
    bus.ch          = 3'd4;
    bus.frame_start = 1'b1;
    @(negedge clk_in);
    bus.ch_load     = 1'b0;
    bus.frame_start = 1'b0;
    check("same_cycle.done", 32'(bus.zoom_done), 1);
    check("same_cycle.mode", 32'(bus.mode_active), 4);
    $display("same-cycle load/frame mode_active %0d", bus.mode_active);

    // Out 4x
    pixel(310, 230, 40, 20, 3240, 1, "out4");
    pixel(299, 230, 0, 0, 0, 0, "out4_left_out");

    // Second request overwrites the first
    load(2, 0, 4, "req_in4");
    load(3, 0, 4, "req_out2");
    frame(1, 3, "apply_out2");
    pixel(280, 210, 0, 0, 0, 1, "out2_origin");
    pixel(319, 269, 78, 118, 18958, 1, "out2_corner");

    // Illegal request rejected, nothing left pending
    load(6, 1, 3, "req_illegal");
    @(negedge clk_in);
    check("illegal.err_off", 32'(bus.mode_err), 0);
    frame(0, 3, "after_illegal");

    // Reset in the middle of a stream
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_in);
      bus.in_valid = 1'b1;
      bus.next_x   = 10'd280;
      bus.next_y   = 10'd210;
    end
    @(negedge clk_in);
    check("midrst.pre_valid", 32'(bus.out_valid), 1);
    @(posedge clk_in);
    #2;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("midrst.valid", 32'(bus.out_valid), 0);
    check("midrst.mode",  32'(bus.mode_active), 0);
    $display("async reset mid-stream out_valid %0d", bus.out_valid);
    @(negedge clk_in);
    reset = 1'b1;
    repeat (4) @(negedge clk_in);
    check("midrst.flushed", 32'(bus.out_valid), 0);
    pixel(240, 180, 0, 0, 0, 1, "post_reset_1x");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
